gpio_control_bank: RTL
======================

GPIO_CONTROL_BANK -- requirements
Module: gpio_control_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of pad channels.
REQ-002 SHALL have parameter PAD_CTRL_BITS, default 13: config bits per channel; minimum 13.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: pad-input synchronizer depth; minimum 2.
REQ-004 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
- wb_clk_i  in  1  sole clock; all flops rising-edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- gpio_defaults  in  NUM_CH*PAD_CTRL_BITS  per-channel power-on config; channel c at [c*PAD_CTRL_BITS +: PAD_CTRL_BITS].
- serial_data_in  in  1  chain input.
- serial_shift  in  1  shift-enable strobe.
- serial_load  in  1  chain-to-config transfer strobe.
- serial_capture  in  1  config-to-chain readback strobe.
- serial_data_out  out  1  chain output.
- user_power_good  in  1  user domain powered.
- mgmt_gpio_out, mgmt_gpio_oeb  in  NUM_CH  management drive and enable.
- mgmt_gpio_in  out  NUM_CH  pad value to management.
- user_gpio_out, user_gpio_oeb  in  NUM_CH  user drive and enable.
- user_gpio_in  out  NUM_CH  pad value to user.
- pad_gpio_holdover, slow_sel, vtrip_sel, inenb, ib_mode_sel, ana_en, ana_sel, ana_pol, outenb, out  out  NUM_CH each  pad controls.
- pad_gpio_dm  out  3*NUM_CH  drive mode.
- pad_gpio_in  in  NUM_CH  pad input.
- irq_rise_en, irq_fall_en  in  NUM_CH  edge-interrupt enables.
- irq_clear  in  NUM_CH  write-1 clear of pending bits.
- irq_pending  out  NUM_CH  latched edge flags.
- irq  out  1  OR of irq_pending.

Function
REQ-005 SHALL use the per-channel bit map MGMT_EN=0, OEB=1, HLDH=2, INP_DIS=3, MOD_SEL=4, AN_EN=5, AN_SEL=6, AN_POL=7, SLOW=8, TRIP=9, DM=12:10. Bits above 12 SHALL be stored and read back, and drive nothing.
REQ-006 SHALL hold a chain register of NUM_CH*PAD_CTRL_BITS bits, with channel 0 in the low bits.
REQ-007 When serial_shift=1, the chain SHALL shift left by one per cycle, with serial_data_in entering bit 0.
REQ-008 serial_data_out SHALL equal the chain MSB, which is a registered value.
REQ-009 When serial_load=1, the config registers SHALL take the chain value as it was before that cycle's edge.
REQ-010 When serial_capture=1, the chain SHALL take the config registers; capture SHALL take priority over shift.
REQ-011 Simultaneous load and capture SHALL swap the chain and config values, each side receiving the other's pre-edge value.
REQ-012 Simultaneous load and shift SHALL load the pre-shift chain into config and also perform the shift.
REQ-013 Each pad static output SHALL be driven directly from its channel's config bit.
REQ-014 pad_gpio_outenb[c] SHALL be: when MGMT_EN=1, (mgmt_gpio_oeb[c] ? OEB : 0); otherwise user_gpio_oeb[c].
REQ-015 pad_gpio_out[c] SHALL be: when MGMT_EN=1 and mgmt_gpio_oeb[c]=1 and DM[2:1]=01, ~DM[0]; otherwise, when MGMT_EN=1, mgmt_gpio_out[c]; otherwise user_gpio_out[c].
REQ-016 mgmt_gpio_in SHALL equal pad_gpio_in combinationally.
REQ-017 user_gpio_in SHALL equal pad_gpio_in & {NUM_CH{user_power_good}}.
REQ-018 Each pad_gpio_in bit SHALL pass through a SYNC_STAGES flop synchronizer followed by a previous-sample flop.
REQ-019 A rising edge SHALL be detected as sync=1 and prev=0; a falling edge as sync=0 and prev=1.
REQ-020 irq_pending[c] SHALL set one cycle after a detected edge whose enable is 1.
REQ-021 irq_pending[c] SHALL clear on irq_clear[c]=1; set SHALL win over a same-cycle clear.
REQ-022 Edge detection SHALL be blanked for SYNC_STAGES+1 cycles after reset deasserts.
REQ-023 irq SHALL be combinational OR of irq_pending.

Reset
REQ-024 With wb_rst_i=1 at a clock edge: config registers <= gpio_defaults, chain <= 0, synchronizers and previous-sample flops <= 0, irq_pending <= 0, blanking counter restarts.
REQ-025 Reset SHALL override shift, load, capture and edges in the same cycle, including mid-shift.

Verification
REQ-026 NUM_CH=4: shift 52 bits of pattern P, then pulse load -> each channel's pad outputs match its slice of P; serial_data_out replays the first bit shifted in.
REQ-027 Pulse capture after reset with gpio_defaults=D, then shift 52 cycles -> serial_data_out emits D MSB-first.
REQ-028 Load and capture in the same cycle with chain=A, config=B -> chain=B, config=A.
REQ-029 Channel 1 with MGMT_EN=1, mgmt_gpio_oeb=1, DM=010 -> pad_gpio_out[1]=1 and pad_gpio_outenb[1]=OEB; with DM=110 -> pad_gpio_out[1]=mgmt_gpio_out[1].
REQ-030 Pad 2 held at 1 through reset -> no irq; then 1->0 with irq_fall_en[2]=1 -> irq_pending[2]=1 exactly SYNC_STAGES+1 cycles later; irq_clear and a new edge in the same cycle -> bit stays 1.
REQ-031 Assert wb_rst_i during a load -> all config registers equal gpio_defaults on the next cycle.

Source files
------------

// File: rtl/gpio_control_bank.sv
// Bank of GPIO pad channels: serial config chain, pad control muxing, input sync
// and edge interrupts.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; gpio_defaults reset config;
//   serial_* chain shift/load/capture and output; mgmt_gpio_*/user_gpio_* drive
//   sources and pad readback; pad_gpio_* pad controls and pad input;
//   irq_* edge enables, write-1 clear, pending flags and combined irq.
module gpio_control_bank #(
  parameter int NUM_CH        = 4,
  parameter int PAD_CTRL_BITS = 13,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_CH*PAD_CTRL_BITS-1:0] gpio_defaults,
  input  logic                            serial_data_in,
  input  logic                            serial_shift,
  input  logic                            serial_load,
  input  logic                            serial_capture,
  output logic                            serial_data_out,
  input  logic                            user_power_good,
  input  logic [NUM_CH-1:0]               mgmt_gpio_out,
  input  logic [NUM_CH-1:0]               mgmt_gpio_oeb,
  output logic [NUM_CH-1:0]               mgmt_gpio_in,
  input  logic [NUM_CH-1:0]               user_gpio_out,
  input  logic [NUM_CH-1:0]               user_gpio_oeb,
  output logic [NUM_CH-1:0]               user_gpio_in,
  output logic [NUM_CH-1:0]               pad_gpio_holdover,
  output logic [NUM_CH-1:0]               pad_gpio_slow_sel,
  output logic [NUM_CH-1:0]               pad_gpio_vtrip_sel,
  output logic [NUM_CH-1:0]               pad_gpio_inenb,
  output logic [NUM_CH-1:0]               pad_gpio_ib_mode_sel,
  output logic [NUM_CH-1:0]               pad_gpio_ana_en,
  output logic [NUM_CH-1:0]               pad_gpio_ana_sel,
  output logic [NUM_CH-1:0]               pad_gpio_ana_pol,
  output logic [NUM_CH-1:0]               pad_gpio_outenb,
  output logic [NUM_CH-1:0]               pad_gpio_out,
  output logic [3*NUM_CH-1:0]             pad_gpio_dm,
  input  logic [NUM_CH-1:0]               pad_gpio_in,
  input  logic [NUM_CH-1:0]               irq_rise_en,
  input  logic [NUM_CH-1:0]               irq_fall_en,
  input  logic [NUM_CH-1:0]               irq_clear,
  output logic [NUM_CH-1:0]               irq_pending,
  output logic                            irq
);

  localparam int W  = NUM_CH * PAD_CTRL_BITS;
  localparam int BW = $clog2(SYNC_STAGES + 2);

  logic [W-1:0] chain_q, chain_d;
  logic [W-1:0] cfg_q, cfg_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [NUM_CH-1:0] sync_s, rise, fall, hit;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    chain_d = chain_q;
    cfg_d   = cfg_q;
    // Load samples the pre-edge chain, so load+capture swaps and
    // load+shift loads the unshifted chain.
    if (serial_load) cfg_d = chain_q;
    if (serial_capture) begin
      chain_d = cfg_q;
    end else if (serial_shift) begin
      chain_d = {chain_q[W-2:0], serial_data_in};
    end
    sync_d[0] = pad_gpio_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = sync_s;
    rise = sync_s & ~prev_q & irq_rise_en;
    fall = ~sync_s & prev_q & irq_fall_en;
    // Ignore edges while the synchronizer refills after reset.
    hit = (blank_q == '0) ? (rise | fall) : '0;
    // Set wins over a same-cycle clear.
    pend_d = (pend_q & ~irq_clear) | hit;
    blank_d = (blank_q == '0) ? '0 : blank_q - BW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chain_q <= '0;
      cfg_q   <= gpio_defaults;
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      blank_q <= BW'(SYNC_STAGES + 1);
    end else begin
      chain_q <= chain_d;
      cfg_q   <= cfg_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      blank_q <= blank_d;
    end
  end

  assign serial_data_out = chain_q[W-1];
  assign irq_pending     = pend_q;
  assign irq             = |pend_q;
  assign mgmt_gpio_in    = pad_gpio_in;
  assign user_gpio_in    = pad_gpio_in & {NUM_CH{user_power_good}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PAD_CTRL_BITS-1:0] cf;
    logic mgmt_en;
    assign cf      = cfg_q[c*PAD_CTRL_BITS +: PAD_CTRL_BITS];
    assign mgmt_en = cf[0];

    assign pad_gpio_holdover[c]    = cf[2];
    assign pad_gpio_inenb[c]       = cf[3];
    assign pad_gpio_ib_mode_sel[c] = cf[4];
    assign pad_gpio_ana_en[c]      = cf[5];
    assign pad_gpio_ana_sel[c]     = cf[6];
    assign pad_gpio_ana_pol[c]     = cf[7];
    assign pad_gpio_slow_sel[c]    = cf[8];
    assign pad_gpio_vtrip_sel[c]   = cf[9];
    assign pad_gpio_dm[3*c +: 3]   = cf[12:10];

    assign pad_gpio_outenb[c] = mgmt_en
                              ? (mgmt_gpio_oeb[c] ? cf[1] : 1'b0)
                              : user_gpio_oeb[c];

    // With mgmt output disabled and DM[2:1]=01 the pad acts as a
    // weak pull whose direction comes from ~DM[0].
    always_comb begin
      pad_gpio_out[c] = user_gpio_out[c];
      if (mgmt_en) begin
        if (mgmt_gpio_oeb[c] && cf[12:11] == 2'b01) begin
          pad_gpio_out[c] = ~cf[10];
        end else begin
          pad_gpio_out[c] = mgmt_gpio_out[c];
        end
      end
    end
  end

endmodule
